// File: rtl/seven_seg_mux_scanner_if.sv
// Display bus for the multiplexed seven-segment scanner: value/brightness inputs and pin-level outputs.
interface seven_seg_mux_scanner_if #(
  parameter int DIGITS = 4
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                  load;
  logic [4*DIGITS-1:0]   digit_data;
  logic [DIGITS-1:0]     digit_en;
  logic [DIGITS-1:0]     dp_in;
  logic [3:0]            brightness;
  logic [DIGITS-1:0]     anode;
  logic [6:0]            seg;
  logic                  dp_n;
  logic [IW-1:0]         digit_idx;
  logic                  frame_start;

  modport master (
    output load, digit_data, digit_en, dp_in, brightness,
    input  anode, seg, dp_n, digit_idx, frame_start
  );

  modport slave (
    input  load, digit_data, digit_en, dp_in, brightness,
    output anode, seg, dp_n, digit_idx, frame_start
  );
endinterface

// File: rtl/seven_seg_mux_scanner.sv
// Multiplexed common-anode seven-segment driver with PWM brightness, ghost blanking
// and frame-synchronous double-buffered digit data.
//
// state    | meaning
// ST_BLANK | all anodes off between digit slots, BLANK_CYCLES long
// ST_ON    | digit r_idx lit-eligible for DWELL_CYCLES, lit while count < threshold
module seven_seg_mux_scanner #(
  parameter int DIGITS       = 4,
  parameter int DWELL_CYCLES = 64,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                   div_clock,
  input  logic                   reset_n,
  seven_seg_mux_scanner_if.slave bus
);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DUTY_STEP  = CW'(DWELL_CYCLES / 16);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       w_idx_nxt;
  logic [CW-1:0]       r_thresh;
  logic [CW-1:0]       w_thresh;
  logic                w_wrap;
  logic                w_enter_on;

  logic [4*DIGITS-1:0] r_pend_data;
  logic [DIGITS-1:0]   r_pend_en;
  logic [DIGITS-1:0]   r_pend_dp;
  logic                r_pend_valid;
  logic [4*DIGITS-1:0] r_act_data;
  logic [DIGITS-1:0]   r_act_en;
  logic [DIGITS-1:0]   r_act_dp;

  logic                w_lit;
  logic [3:0]          w_nibble;
  logic [DIGITS-1:0]   w_anode_nxt;
  logic [6:0]          w_seg_nxt;
  logic                w_dp_n_nxt;
  logic                w_fs_nxt;

  logic [DIGITS-1:0]   r_anode;
  logic [6:0]          r_seg;
  logic                r_dp_n;
  logic [IW-1:0]       r_idx_out;
  logic                r_frame_start;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign w_thresh = CW'(bus.brightness) * DUTY_STEP;

  always_ff @(posedge div_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_BLANK;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_thresh <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      if (w_enter_on) begin
        r_thresh <= w_thresh;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_wrap      = 1'b0;
    w_enter_on  = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = ST_ON;
          w_cnt_nxt   = '0;
          w_enter_on  = 1'b1;
        end
      end
      ST_ON: begin
        if (r_cnt == DWELL_LAST) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt = '0;
            w_wrap    = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A load landing on the wrap cycle overwrites pending after the commit, so it shows next frame.
  always_ff @(posedge div_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_data  <= '0;
      r_pend_en    <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_act_data   <= '0;
      r_act_en     <= '0;
      r_act_dp     <= '0;
    end else begin
      if (w_wrap) begin
        if (r_pend_valid) begin
          r_act_data <= r_pend_data;
          r_act_en   <= r_pend_en;
          r_act_dp   <= r_pend_dp;
        end
        r_pend_valid <= 1'b0;
      end
      if (bus.load) begin
        r_pend_data  <= bus.digit_data;
        r_pend_en    <= bus.digit_en;
        r_pend_dp    <= bus.dp_in;
        r_pend_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    w_nibble    = r_act_data[{r_idx, 2'b00} +: 4];
    w_lit       = (r_state == ST_ON) && (r_cnt < r_thresh) && r_act_en[r_idx];
    w_anode_nxt = '1;
    w_seg_nxt   = 7'h7F;
    w_dp_n_nxt  = 1'b1;
    if (w_lit) begin
      w_anode_nxt = ~(DIGITS'(1) << r_idx);
      w_seg_nxt   = hex_to_seg(w_nibble);
      w_dp_n_nxt  = ~r_act_dp[r_idx];
    end
    w_fs_nxt = (r_state == ST_BLANK) && (r_cnt == '0) && (r_idx == '0);
  end

  always_ff @(posedge div_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_anode       <= '1;
      r_seg         <= 7'h7F;
      r_dp_n        <= 1'b1;
      r_idx_out     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_anode       <= w_anode_nxt;
      r_seg         <= w_seg_nxt;
      r_dp_n        <= w_dp_n_nxt;
      r_idx_out     <= r_idx;
      r_frame_start <= w_fs_nxt;
    end
  end

  assign bus.anode       = r_anode;
  assign bus.seg         = r_seg;
  assign bus.dp_n        = r_dp_n;
  assign bus.digit_idx   = r_idx_out;
  assign bus.frame_start = r_frame_start;
endmodule
